uart_tx_ext: RTL and testbench

- Parametrised successor to the team's fixed-format UART transmitter.
- Adds a write-side FIFO, a runtime baud divisor, runtime parity (none/even/odd) and a runtime choice of 1 or 2 stop bits.
- Word width is generic.
- Sits between any producer (CPU bus bridge, debug logger) and the board TX pin; the producer writes bytes without waiting for each frame to finish.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 72 +++++++
 rtl/uart_tx_ext.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_ext.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the extended UART transmitter: parity modes, serializer states,
// and the smallest bit period the timer supports.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int MIN_DIV = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock circular FIFO that buffers producer words ahead of the serializer.
// A write while full and a read while empty are ignored.
module uart_tx_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic          wen,
    input  logic [DW-1:0] din,
    input  logic          ren,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_wr    = wen && !full;
        do_rd    = ren && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_ext.sv
// UART transmitter with a write FIFO, runtime baud divisor, parity and stop-bit count.
// Line settings are captured when a word is popped, so each frame is self-consistent.
module uart_tx_ext
    import uart_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int DIVW  = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            CLK,
    input  logic            RST_X,
    input  logic [DIVW-1:0] div,
    input  logic [1:0]      par_mode,
    input  logic            stop2,
    input  logic            wen,
    input  logic [DW-1:0]   din,
    output logic            full,
    output logic [CW-1:0]   count,
    output logic            busy,
    output logic            TX
);

    localparam int BCW = $clog2(DW);

    tx_state_e       state_q, state_d;
    logic [DIVW-1:0] timer_q, timer_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [BCW-1:0]  bit_q, bit_d;
    logic            par_en_q, par_en_d;
    logic            par_bit_q, par_bit_d;
    logic            stop2_q, stop2_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;

    logic            pop;
    logic            bit_end;
    logic [DIVW-1:0] div_in_eff;
    logic [DW-1:0]   f_dout;
    logic            f_full;
    logic            f_empty;

    // Producer handshake: a word is taken on any edge with wen=1 and full=0;
    // writes while full are dropped, and a same-cycle pop does not free a slot.
    uart_tx_fifo #(
        .DW   (DW),
        .DEPTH(DEPTH),
        .CW   (CW)
    ) u_fifo (
        .CLK  (CLK),
        .RST_X(RST_X),
        .wen  (wen),
        .din  (din),
        .ren  (pop),
        .dout (f_dout),
        .full (f_full),
        .empty(f_empty),
        .count(count)
    );

    assign full = f_full;
    assign busy = busy_q;
    assign TX   = tx_q;

    always_comb begin
        div_in_eff = (div < DIVW'(MIN_DIV)) ? DIVW'(MIN_DIV) : div;
        bit_end    = (timer_q == '0);
        pop        = 1'b0;
        state_d    = state_q;
        timer_d    = timer_q;
        div_d      = div_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;

        if (state_q != IDLE) begin
            timer_d = bit_end ? (div_q - 1'b1) : (timer_q - 1'b1);
        end

        case (state_q)
            IDLE: begin
                if (!f_empty) pop = 1'b1;
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BCW'(DW - 1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                // bit_q counts completed stop periods; the next frame is popped in the last one.
                if (bit_end) begin
                    if (stop2_q && (bit_q == '0)) begin
                        bit_d = 1'b1;
                    end else if (!f_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            state_d   = START;
            shift_d   = f_dout;
            div_d     = div_in_eff;
            timer_d   = div_in_eff - 1'b1;
            bit_d     = '0;
            stop2_d   = stop2;
            par_bit_d = (par_mode == PAR_ODD) ^ (^f_dout);
            case (par_mode)
                PAR_EVEN, PAR_ODD: par_en_d = 1'b1;
                PAR_NONE:          par_en_d = 1'b0;
                default:           par_en_d = 1'b0;
            endcase
        end

        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            PARITY:  tx_d = par_bit_q;
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_q != IDLE) || !f_empty || (wen && !f_full);
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            div_q     <= DIVW'(MIN_DIV);
            shift_q   <= '0;
            bit_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_q     <= div_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ext.sv
// Bench for uart_tx_ext: a line monitor rebuilds each expected frame waveform from a
// queue of {stop2, par_mode, div, data} entries pushed as words are written.
module tb_uart_tx_ext;

  localparam int EW = 27;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic [15:0] div = 16'd4;
  logic [1:0]  par_mode = 2'b00;
  logic        stop2 = 1'b0;
  logic        wen = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        full;
  logic [2:0]  count;
  logic        busy;
  logic        TX;

  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0] exp_q[$];
  bit            mon_active = 1'b0;
  int            idle_run = 1;
  int            contig_cnt = 0;

  uart_tx_ext #(
    .DW(8), .DEPTH(4), .DIVW(16)
  ) dut (
    .CLK(CLK), .RST_X(RST_X), .div(div), .par_mode(par_mode), .stop2(stop2),
    .wen(wen), .din(din), .full(full), .count(count), .busy(busy), .TX(TX)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected line waveform, one sample per clock, bit 0 = first sample of the start bit.
  task automatic build_frame(input logic [EW-1:0] e, output logic [127:0] w, output int len);
    logic [7:0]  d;
    logic [15:0] dv;
    int          de;
    logic [1:0]  pm;
    logic        bits[13];
    int          nb;
    d  = e[7:0];
    dv = e[23:8];
    pm = e[25:24];
    de = (dv < 16'd2) ? 2 : int'(dv);
    nb = 0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < 8; i++) begin
      bits[nb] = d[i]; nb++;
    end
    if (pm == 2'b01) begin bits[nb] = ^d;  nb++; end
    if (pm == 2'b10) begin bits[nb] = ~^d; nb++; end
    bits[nb] = 1'b1; nb++;
    if (e[26]) begin bits[nb] = 1'b1; nb++; end
    w   = '0;
    len = 0;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < de; k++) begin
        w[len] = bits[b];
        len++;
      end
    end
  endtask

  task automatic monitor();
    logic [127:0]  obs;
    logic [127:0]  expw;
    logic [EW-1:0] e;
    int            len;
    int            pos;
    obs = '0; expw = '0; len = 0; pos = 0;
    forever begin
      @(negedge CLK);
      if (!RST_X) begin
        mon_active = 1'b0;
        idle_run   = 1;
      end else begin
        if (!mon_active && TX === 1'b0) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_frame: line went low at %0t, required no frame", $time);
          end else begin
            e = exp_q.pop_front();
            build_frame(e, expw, len);
            obs = '0;
            pos = 0;
            mon_active = 1'b1;
            if (idle_run == 0) contig_cnt++;
          end
        end
        if (mon_active) begin
          obs[pos] = TX;
          pos++;
          if (pos == len) begin
            n_checks++;
            if (obs !== expw) begin
              n_errors++;
              $display("FAIL frame data=%02h: got %h required %h (len %0d)", e[7:0], obs, expw, len);
            end
            mon_active = 1'b0;
            idle_run   = 0;
          end
        end else begin
          idle_run++;
        end
      end
    end
  endtask

  task automatic write_word(input logic [7:0] d, input logic [15:0] ediv, input logic [1:0] epar,
                            input logic estop, input bit push);
    wen = 1'b1;
    din = d;
    if (push) exp_q.push_back({estop, epar, ediv, d});
    tick();
    wen = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((busy !== 1'b0 || mon_active) && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, k);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL frames_missing: %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    RST_X = 1'b0;
    tick(); tick();
    n_checks++; if (TX !== 1'b1)    begin n_errors++; $display("FAIL reset_tx: got %b required 1", TX); end
    n_checks++; if (busy !== 1'b0)  begin n_errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (full !== 1'b0)  begin n_errors++; $display("FAIL reset_full: got %b required 0", full); end
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d required 0", count); end
    RST_X = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int nb;
    div = 16'd4; par_mode = 2'b00; stop2 = 1'b0;
    write_word(8'h55, 16'd4, 2'b00, 1'b0, 1'b1);
    n_checks++; if (count !== 3'd1) begin n_errors++; $display("FAIL basic_count_n: got %0d required 1", count); end
    n_checks++; if (busy !== 1'b1)  begin n_errors++; $display("FAIL basic_busy_n: got %b required 1", busy); end
    tick();
    n_checks++; if (TX !== 1'b1)    begin n_errors++; $display("FAIL basic_tx_n1: got %b required 1", TX); end
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL basic_count_n1: got %0d required 0", count); end
    tick();
    n_checks++; if (TX !== 1'b0)    begin n_errors++; $display("FAIL basic_tx_n2: got %b required 0", TX); end
    nb = 0;
    while (busy === 1'b1 && nb < 200) begin tick(); nb++; end
    n_checks++; if (nb != 40) begin n_errors++; $display("FAIL basic_busy_fall: fell %0d cycles after N+2, required 40", nb); end
    wait_idle(100);
  endtask

  task automatic test_parity();
    int nb;
    div = 16'd4; par_mode = 2'b01; stop2 = 1'b0;
    write_word(8'h07, 16'd4, 2'b01, 1'b0, 1'b1);
    wait_idle(200);
    par_mode = 2'b10; stop2 = 1'b1;
    write_word(8'h07, 16'd4, 2'b10, 1'b1, 1'b1);
    nb = 0;
    while (busy === 1'b1 && nb < 200) begin tick(); nb++; end
    n_checks++; if (nb != 50) begin n_errors++; $display("FAIL parity_stop2_len: busy fell %0d after accept, required 50", nb); end
    wait_idle(100);
    par_mode = 2'b00; stop2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int nb;
    int cmax;
    int c0;
    c0 = contig_cnt;
    cmax = 0;
    write_word(8'h01, 16'd4, 2'b00, 1'b0, 1'b1);
    if (int'(count) > cmax) cmax = int'(count);
    write_word(8'h02, 16'd4, 2'b00, 1'b0, 1'b1);
    if (int'(count) > cmax) cmax = int'(count);
    write_word(8'h03, 16'd4, 2'b00, 1'b0, 1'b1);
    n_checks++; if (TX !== 1'b0) begin n_errors++; $display("FAIL b2b_first_start: got %b required 0", TX); end
    nb = 0;
    while (busy === 1'b1 && nb < 400) begin
      if (int'(count) > cmax) cmax = int'(count);
      nb++;
      tick();
    end
    n_checks++; if (nb != 120) begin n_errors++; $display("FAIL b2b_busy_len: got %0d required 120", nb); end
    n_checks++; if (cmax != 2) begin n_errors++; $display("FAIL b2b_count_peak: got %0d required 2", cmax); end
    wait_idle(100);
    n_checks++;
    if (contig_cnt - c0 != 2) begin
      n_errors++;
      $display("FAIL b2b_contiguous: got %0d gapless starts required 2", contig_cnt - c0);
    end
  endtask

  task automatic test_overflow();
    write_word(8'h11, 16'd4, 2'b00, 1'b0, 1'b1);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      write_word(8'hA0 + 8'(i), 16'd4, 2'b00, 1'b0, 1'b1);
    end
    n_checks++; if (full !== 1'b1)  begin n_errors++; $display("FAIL ovf_full: got %b required 1", full); end
    n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL ovf_count4: got %0d required 4", count); end
    write_word(8'hA4, 16'd4, 2'b00, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL ovf_drop_count: got %0d required 4", count); end
    n_checks++; if (full !== 1'b1)  begin n_errors++; $display("FAIL ovf_drop_full: got %b required 1", full); end
    wait_idle(800);
  endtask

  task automatic test_cfg_change();
    int nb;
    div = 16'd4; par_mode = 2'b00; stop2 = 1'b0;
    write_word(8'h3C, 16'd4, 2'b00, 1'b0, 1'b1);
    write_word(8'hC1, 16'd8, 2'b01, 1'b0, 1'b1);
    repeat (10) tick();
    div = 16'd8; par_mode = 2'b01;
    wait_idle(400);
    div = 16'd0; par_mode = 2'b00;
    write_word(8'h96, 16'd0, 2'b00, 1'b0, 1'b1);
    nb = 0;
    while (busy === 1'b1 && nb < 200) begin tick(); nb++; end
    n_checks++; if (nb != 22) begin n_errors++; $display("FAIL div0_len: busy fell %0d after accept, required 22", nb); end
    wait_idle(100);
    div = 16'd4;
  endtask

  task automatic test_reset_midframe();
    int bad;
    write_word(8'hE7, 16'd4, 2'b00, 1'b0, 1'b1);
    write_word(8'h81, 16'd4, 2'b00, 1'b0, 1'b0);
    write_word(8'h42, 16'd4, 2'b00, 1'b0, 1'b0);
    repeat (8) tick();
    RST_X = 1'b0;
    #1;
    n_checks++; if (TX !== 1'b1)    begin n_errors++; $display("FAIL rst_mid_tx: got %b required 1", TX); end
    n_checks++; if (busy !== 1'b0)  begin n_errors++; $display("FAIL rst_mid_busy: got %b required 0", busy); end
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL rst_mid_count: got %0d required 0", count); end
    exp_q.delete();
    tick(); tick();
    RST_X = 1'b1;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (TX !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL rst_quiet: %0d active cycles after release, required 0", bad); end
    write_word(8'h5A, 16'd4, 2'b00, 1'b0, 1'b1);
    wait_idle(200);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_overflow();
    test_cfg_change();
    test_reset_midframe();
    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
